// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (and the future RX engine).
package uart_pkg;

    // Transmit FSM states
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    // Parity mode encodings as seen on cfg_par
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    localparam logic [3:0] DLEN_MIN = 4'd5;
    localparam logic [3:0] DLEN_MAX = 4'd9;
    localparam logic [3:0] DLEN_DEF = 4'd8;

    // Out-of-range data lengths fall back to 8 bits
    function automatic logic [3:0] eff_dlen(input logic [3:0] dlen);
        if (dlen >= DLEN_MIN && dlen <= DLEN_MAX) begin
            return dlen;
        end
        return DLEN_DEF;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with level/empty/full and a synchronous flush.
// Read data is the head entry, valid whenever empty is low (no bypass).
module uart_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; not reset, contents only visible through valid entries
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Occupancy next-state; flush wins over simultaneous push/pop
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign level = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW + 1)'(DEPTH));

endmodule

// File: rtl/uart_tx_engine_p.sv
// UART transmit engine: TX FIFO, per-frame shadowed config, baud divider,
// 5..9 data bits, parity, 1/2 stop bits and CTS gating at frame start.
module uart_tx_engine_p
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned MAX_DW     = 9
) (
    input  logic                          pclk,
    input  logic                          prst_n,
    input  logic                          cfg_en,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [3:0]                    cfg_dlen,
    input  logic [1:0]                    cfg_par,
    input  logic                          cfg_stop2,
    input  logic                          cfg_cts_en,
    input  logic                          cfg_flush,
    input  logic                          wr_valid,
    input  logic [MAX_DW-1:0]             wr_data,
    output logic                          wr_ready,
    input  logic                          uart_cts,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_empty,
    output logic                          fifo_full
);

    tx_state_e state_q, state_d;

    logic              cts_meta_q, cts_s_q;
    logic [DIV_W-1:0]  cnt_q, div_q;
    logic [3:0]        dlen_q, bit_cnt_q, load_dlen;
    logic [1:0]        par_q;
    logic              stop2_q, stop_cnt_q, par_bit_q, load_par_bit;
    logic [MAX_DW-1:0] shift_q, fifo_rdata;

    logic tick, last_data, last_stop, start_ok, load, fifo_push;

    assign wr_ready  = prst_n && !fifo_full;
    assign fifo_push = wr_valid && wr_ready;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MAX_DW)
    ) u_fifo (
        .clk   (pclk),
        .rst_n (prst_n),
        .flush (cfg_flush),
        .push  (fifo_push),
        .wdata (wr_data),
        .pop   (load),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Two-flop synchroniser for the asynchronous active-low CTS input
    always_ff @(posedge pclk) begin
        if (!prst_n) begin
            cts_meta_q <= 1'b1;
            cts_s_q    <= 1'b1;
        end else begin
            cts_meta_q <= uart_cts;
            cts_s_q    <= cts_meta_q;
        end
    end

    assign tick      = (state_q != StIdle) && (cnt_q == '0);
    assign last_data = (bit_cnt_q == dlen_q - 4'd1);
    assign last_stop = (stop_cnt_q == stop2_q);
    assign start_ok  = cfg_en && !fifo_empty && (!cfg_cts_en || !cts_s_q);

    // Parity of the word about to be loaded, over the live (not shadow) config
    always_comb begin
        logic xr;
        xr        = 1'b0;
        load_dlen = eff_dlen(cfg_dlen);
        for (int i = 0; i < int'(MAX_DW); i++) begin
            if (i < int'(load_dlen)) begin
                xr = xr ^ fifo_rdata[i];
            end
        end
        unique case (cfg_par)
            PAR_EVEN: load_par_bit = xr;
            PAR_ODD:  load_par_bit = ~xr;
            PAR_MARK: load_par_bit = 1'b1;
            default:  load_par_bit = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge pclk) begin
        if (!prst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; load marks the edge that pops the FIFO and starts a frame
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        if (state_q != StIdle && !cfg_en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        state_d = StStart;
                        load    = 1'b1;
                    end
                end
                StStart: begin
                    if (tick) begin
                        state_d = StData;
                    end
                end
                StData: begin
                    if (tick && last_data) begin
                        state_d = (par_q != PAR_NONE) ? StParity : StStop;
                    end
                end
                StParity: begin
                    if (tick) begin
                        state_d = StStop;
                    end
                end
                StStop: begin
                    if (tick && last_stop) begin
                        if (start_ok) begin
                            state_d = StStart;
                            load    = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath: shadow config, baud counter, shift register and bit counters
    always_ff @(posedge pclk) begin
        if (!prst_n) begin
            cnt_q      <= '0;
            div_q      <= '0;
            dlen_q     <= DLEN_DEF;
            par_q      <= PAR_NONE;
            stop2_q    <= 1'b0;
            par_bit_q  <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else if (load) begin
            shift_q    <= fifo_rdata;
            div_q      <= cfg_div;
            dlen_q     <= load_dlen;
            par_q      <= cfg_par;
            stop2_q    <= cfg_stop2;
            par_bit_q  <= load_par_bit;
            cnt_q      <= cfg_div;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else if (state_d == StIdle) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= div_q;
            if (state_q == StData) begin
                shift_q   <= shift_q >> 1;
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (state_q == StStop) begin
                stop_cnt_q <= 1'b1;
            end
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // FSM outputs decoded from registered state
    always_comb begin
        unique case (state_q)
            StIdle:   uart_tx = 1'b1;
            StStart:  uart_tx = 1'b0;
            StData:   uart_tx = shift_q[0];
            StParity: uart_tx = par_bit_q;
            StStop:   uart_tx = 1'b1;
            default:  uart_tx = 1'b1;
        endcase
        tx_busy = (state_q != StIdle);
        tx_done = (state_q == StStop) && tick && last_stop && cfg_en;
    end

endmodule

// File: tb/tb_uart_tx_engine_p.sv
module tb_uart_tx_engine_p;

    logic        pclk = 1'b0;
    logic        prst_n;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic [3:0]  cfg_dlen;
    logic [1:0]  cfg_par;
    logic        cfg_stop2;
    logic        cfg_cts_en;
    logic        cfg_flush;
    logic        wr_valid;
    logic [8:0]  wr_data;
    logic        wr_ready;
    logic        uart_cts;
    logic        uart_tx;
    logic        tx_busy;
    logic        tx_done;
    logic [4:0]  fifo_level;
    logic        fifo_empty;
    logic        fifo_full;

    int total = 0;
    int bad   = 0;

    uart_tx_engine_p #(
        .FIFO_DEPTH (16),
        .DIV_W      (16),
        .MAX_DW     (9)
    ) dut (
        .pclk       (pclk),
        .prst_n     (prst_n),
        .cfg_en     (cfg_en),
        .cfg_div    (cfg_div),
        .cfg_dlen   (cfg_dlen),
        .cfg_par    (cfg_par),
        .cfg_stop2  (cfg_stop2),
        .cfg_cts_en (cfg_cts_en),
        .cfg_flush  (cfg_flush),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .uart_cts   (uart_cts),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_level (fifo_level),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full)
    );

    always #5 pclk = ~pclk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic set_cfg(input int div, input logic [3:0] dlen, input logic [1:0] par,
                           input logic s2);
        cfg_div   = 16'(div);
        cfg_dlen  = dlen;
        cfg_par   = par;
        cfg_stop2 = s2;
    endtask

    task automatic test_reset();
        prst_n = 1'b0; cfg_en = 1'b0; cfg_cts_en = 1'b0; cfg_flush = 1'b0;
        wr_valid = 1'b0; wr_data = '0; uart_cts = 1'b0;
        set_cfg(3, 4'd8, 2'b00, 1'b0);
        repeat (3) @(negedge pclk);
        total++;
        if ({uart_tx, tx_busy, tx_done, fifo_empty, fifo_full, wr_ready} !== 6'b100100) begin
            bad++;
            $display("FAIL reset_outputs: got %b want %b",
                     {uart_tx, tx_busy, tx_done, fifo_empty, fifo_full, wr_ready}, 6'b100100);
        end
        total++;
        if (fifo_level !== 5'd0) begin
            bad++; $display("FAIL reset_level: got %0d want 0", fifo_level);
        end
        prst_n = 1'b1;
        @(negedge pclk);
        total++;
        if (wr_ready !== 1'b1) begin
            bad++; $display("FAIL reset_wr_ready_after: got %b want 1", wr_ready);
        end
    endtask

    task automatic test_8n1();
        logic [9:0] bits;
        bits = 10'b1010101010;  // start, 0x55 LSB first, stop
        set_cfg(3, 4'd8, 2'b00, 1'b0);
        cfg_en   = 1'b1;
        wr_valid = 1'b1; wr_data = 9'h055;
        @(negedge pclk);
        wr_valid = 1'b0;
        total++;
        if ({fifo_level, uart_tx, tx_busy} !== {5'd1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL 8n1_no_bypass: got lvl=%0d tx=%b busy=%b want lvl=1 tx=1 busy=0",
                     fifo_level, uart_tx, tx_busy);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge pclk);
            total++;
            if (uart_tx !== bits[k/4]) begin
                bad++; $display("FAIL 8n1_line c%0d: got %b want %b", k + 1, uart_tx, bits[k/4]);
            end
            total++;
            if (tx_done !== (k == 39)) begin
                bad++; $display("FAIL 8n1_done c%0d: got %b want %b", k + 1, tx_done, (k == 39));
            end
            if (k == 0) begin
                total++;
                if ({tx_busy, fifo_empty} !== 2'b11) begin
                    bad++; $display("FAIL 8n1_start: got busy,empty=%b want 11",
                                    {tx_busy, fifo_empty});
                end
            end
        end
        @(negedge pclk);
        total++;
        if ({tx_busy, uart_tx, tx_done} !== 3'b010) begin
            bad++; $display("FAIL 8n1_end: got busy,tx,done=%b want 010",
                            {tx_busy, uart_tx, tx_done});
        end
    endtask

    task automatic test_formats();
        int          divs [2] = '{0, 1};
        logic [3:0]  dls  [2] = '{4'd7, 4'd9};
        logic [1:0]  pars [2] = '{2'b01, 2'b10};
        logic        s2s  [2] = '{1'b1, 1'b0};
        logic [8:0]  dat  [2] = '{9'h07F, 9'h1FF};
        // 7E2: start, seven ones, parity 1, two stops; 9O1: start, nine ones, parity 0, stop
        logic [11:0] exb  [2] = '{12'b011111111110, 12'b101111111110};
        int          lens [2] = '{11, 24};
        for (int f = 0; f < 2; f++) begin
            set_cfg(divs[f], dls[f], pars[f], s2s[f]);
            wr_valid = 1'b1; wr_data = dat[f];
            @(negedge pclk);
            wr_valid = 1'b0;
            for (int k = 0; k < lens[f]; k++) begin
                @(negedge pclk);
                total++;
                if (uart_tx !== exb[f][k / (divs[f] + 1)]) begin
                    bad++; $display("FAIL fmt%0d_line c%0d: got %b want %b", f, k + 1, uart_tx,
                                    exb[f][k / (divs[f] + 1)]);
                end
                total++;
                if (tx_done !== (k == lens[f] - 1)) begin
                    bad++; $display("FAIL fmt%0d_done c%0d: got %b want %b", f, k + 1, tx_done,
                                    (k == lens[f] - 1));
                end
            end
            @(negedge pclk);
            total++;
            if (tx_busy !== 1'b0) begin
                bad++; $display("FAIL fmt%0d_len: busy got %b want 0", f, tx_busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int         waited;
        logic [8:0] word;
        logic       exp;
        set_cfg(0, 4'd8, 2'b00, 1'b0);
        cfg_cts_en = 1'b1;
        uart_cts   = 1'b1;
        repeat (3) @(negedge pclk);
        for (int i = 0; i < 17; i++) begin
            total++;
            if ({wr_ready, fifo_level} !== {(i < 16), 5'(i)}) begin
                bad++; $display("FAIL fill_%0d: got rdy=%b lvl=%0d want rdy=%b lvl=%0d",
                                i, wr_ready, fifo_level, (i < 16), i);
            end
            wr_valid = 1'b1; wr_data = 9'h0A5 ^ 9'(i);
            @(negedge pclk);
        end
        wr_valid = 1'b0;
        total++;
        if ({fifo_full, wr_ready, tx_busy, fifo_level} !== {3'b100, 5'd16}) begin
            bad++; $display("FAIL fill_full: got full,rdy,busy=%b lvl=%0d want 100 lvl=16",
                            {fifo_full, wr_ready, tx_busy}, fifo_level);
        end
        uart_cts = 1'b0;
        waited   = 0;
        while (!tx_busy && waited < 10) begin
            @(negedge pclk);
            waited++;
        end
        total++;
        if (waited !== 3) begin
            bad++; $display("FAIL cts_latency: got %0d cycles want 3", waited);
        end
        total++;
        if (fifo_level !== 5'd15) begin
            bad++; $display("FAIL cts_first_pop: lvl got %0d want 15", fifo_level);
        end
        for (int k = 0; k < 160; k++) begin
            if (k > 0) @(negedge pclk);
            word = 9'h0A5 ^ 9'(k / 10);
            if (k % 10 == 0) exp = 1'b0;
            else if (k % 10 == 9) exp = 1'b1;
            else exp = word[(k % 10) - 1];
            total++;
            if ({uart_tx, tx_busy, tx_done} !== {exp, 1'b1, (k % 10 == 9)}) begin
                bad++; $display("FAIL b2b c%0d: got tx,busy,done=%b want %b", k,
                                {uart_tx, tx_busy, tx_done}, {exp, 1'b1, (k % 10 == 9)});
            end
        end
        @(negedge pclk);
        total++;
        if ({tx_busy, fifo_empty} !== 2'b01) begin
            bad++; $display("FAIL b2b_end: got busy,empty=%b want 01", {tx_busy, fifo_empty});
        end
        cfg_cts_en = 1'b0;
    endtask

    task automatic test_div_change();
        logic [9:0] a_bits, b_bits;
        logic       exp;
        a_bits = 10'b1000011110;  // 0x0F framed
        b_bits = 10'b1111100000;  // 0xF0 framed
        set_cfg(3, 4'd8, 2'b00, 1'b0);
        wr_valid = 1'b1; wr_data = 9'h00F;
        @(negedge pclk);
        wr_data = 9'h0F0;
        @(negedge pclk);
        wr_valid = 1'b0;
        total++;
        if (fifo_level !== 5'd1) begin
            bad++; $display("FAIL div_push_pop: lvl got %0d want 1", fifo_level);
        end
        for (int k = 0; k < 120; k++) begin
            if (k > 0) @(negedge pclk);
            exp = (k < 40) ? a_bits[k / 4] : b_bits[(k - 40) / 8];
            total++;
            if ({uart_tx, tx_done} !== {exp, (k == 39 || k == 119)}) begin
                bad++; $display("FAIL divchg c%0d: got tx,done=%b want %b", k,
                                {uart_tx, tx_done}, {exp, (k == 39 || k == 119)});
            end
            if (k == 10) cfg_div = 16'd7;
        end
        @(negedge pclk);
        total++;
        if (tx_busy !== 1'b0) begin
            bad++; $display("FAIL divchg_end: busy got %b want 0", tx_busy);
        end
    endtask

    task automatic test_abort_flush();
        set_cfg(3, 4'd8, 2'b00, 1'b0);
        wr_valid = 1'b1; wr_data = 9'h0AA;
        @(negedge pclk);
        wr_data = 9'h033;
        @(negedge pclk);
        wr_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge pclk);
            total++;
            if (tx_busy !== 1'b1) begin
                bad++; $display("FAIL abort_pre c%0d: busy got %b want 1", k, tx_busy);
            end
        end
        cfg_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge pclk);
            total++;
            if ({uart_tx, tx_busy, tx_done, fifo_level} !== {3'b100, 5'd1}) begin
                bad++; $display("FAIL abort c%0d: got tx,busy,done=%b lvl=%0d want 100 lvl=1",
                                k, {uart_tx, tx_busy, tx_done}, fifo_level);
            end
        end
        cfg_flush = 1'b1; wr_valid = 1'b1; wr_data = 9'h1AA;
        @(negedge pclk);
        cfg_flush = 1'b0; wr_valid = 1'b0;
        total++;
        if ({fifo_level, fifo_empty, fifo_full} !== {5'd0, 2'b10}) begin
            bad++; $display("FAIL flush: got lvl=%0d empty,full=%b want lvl=0 10",
                            fifo_level, {fifo_empty, fifo_full});
        end
        cfg_en = 1'b1;
        repeat (2) @(negedge pclk);
        total++;
        if ({tx_busy, uart_tx} !== 2'b01) begin
            bad++; $display("FAIL flush_idle: got busy,tx=%b want 01", {tx_busy, uart_tx});
        end
    endtask

    task automatic test_reset_mid_frame();
        set_cfg(1, 4'd8, 2'b00, 1'b0);
        wr_valid = 1'b1; wr_data = 9'h000;
        repeat (3) @(negedge pclk);
        wr_valid = 1'b0;
        total++;
        if ({tx_busy, uart_tx, fifo_level} !== {2'b10, 5'd2}) begin
            bad++; $display("FAIL rst_pre: got busy,tx=%b lvl=%0d want 10 lvl=2",
                            {tx_busy, uart_tx}, fifo_level);
        end
        repeat (4) @(negedge pclk);
        prst_n = 1'b0;
        @(negedge pclk);
        total++;
        if ({uart_tx, tx_busy, tx_done, fifo_empty, fifo_full, wr_ready, fifo_level}
            !== {6'b100100, 5'd0}) begin
            bad++; $display("FAIL rst_mid: got %b lvl=%0d want 100100 lvl=0",
                            {uart_tx, tx_busy, tx_done, fifo_empty, fifo_full, wr_ready},
                            fifo_level);
        end
        prst_n = 1'b1;
        repeat (3) @(negedge pclk);
        total++;
        if ({wr_ready, tx_busy, uart_tx, fifo_empty} !== 4'b1011) begin
            bad++; $display("FAIL rst_release: got rdy,busy,tx,empty=%b want 1011",
                            {wr_ready, tx_busy, uart_tx, fifo_empty});
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_formats();
        test_back_to_back();
        test_div_change();
        test_abort_flush();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end, total=%0d bad=%0d",
                 total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_engine_p.md
Name: uart_tx_engine_p

Overview:
Parametrised next-generation UART transmit engine: an internal TX FIFO, a 16-bit baud divider, runtime-selectable 5–9 data bits, parity mode and 1/2 stop bits, plus CTS flow control.
It sits between the APB register block (FIFO writes, config) and the uart_tx pin.
It replaces the fixed 8/9-bit, 8-bit-divider transmit path.
All config is shadow-latched per frame, so software may reprogram while a frame is on the line.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of 2, 2..256
DIV_W, 16, width of baud divisor
MAX_DW, 9, maximum data bits; FIFO entry width

Ports:
pclk  in  1  clock
prst_n  in  1  reset
cfg_en  in  1  transmitter enable
cfg_div  in  DIV_W  bit period = cfg_div+1 pclk cycles
cfg_dlen  in  4  data bits, 5..9; other values treated as 8
cfg_par  in  2  00 none, 01 even, 10 odd, 11 mark (1)
cfg_stop2  in  1  1 = two stop bits
cfg_cts_en  in  1  enable CTS gating
cfg_flush  in  1  synchronous FIFO clear
wr_valid  in  1  FIFO write request
wr_data  in  MAX_DW  frame data, LSB first on line
wr_ready  out  1  FIFO accepts write
uart_cts  in  1  async, active-low clear-to-send
uart_tx  out  1  serial line, idle high
tx_busy  out  1  frame in progress
tx_done  out  1  one-cycle pulse at end of last stop bit
fifo_level  out  $clog2(FIFO_DEPTH)+1  current entries
fifo_empty  out  1
fifo_full  out  1

Behaviour:
- Clocking and reset: one clock, pclk; reset prst_n is synchronous and active-low.
- Reset values:
  - uart_tx=1, tx_busy=0, tx_done=0.
  - fifo_level=0, fifo_empty=1, fifo_full=0.
  - wr_ready=0 while prst_n=0.
  - FSM in IDLE, baud counter 0, CTS sync flops 1.
- Reset mid-frame aborts immediately; uart_tx is high on the next edge.
- FIFO:
  - Push when wr_valid&&wr_ready; wr_ready=!fifo_full.
  - Pop only by the FSM. No bypass: a word written into an empty FIFO is poppable the cycle after the write.
  - Simultaneous push and pop leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - cfg_flush has priority over push/pop in the same cycle: level becomes 0. An in-flight frame continues.
- CTS: uart_cts passes through a 2-flop synchroniser (cts_s). It is checked only at frame start; deassertion mid-frame never aborts a frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when cfg_en && !fifo_empty && (!cfg_cts_en || !cts_s).
    - Same edge: pop FIFO, load shift register, latch shadow copies of cfg_div/dlen/par/stop2, load baud counter with cfg_div.
    - uart_tx=0 and tx_busy=1 from the next cycle.
  - Baud counter: decrements each cycle in non-IDLE states. A tick occurs at count 0, which then reloads the shadow div. Each bit lasts div+1 cycles; div=0 gives 1 cycle per bit.
  - START -> DATA on tick. DATA shifts LSB first for dlen bits.
  - DATA -> PARITY on the last data tick if par!=00, else -> STOP.
    - Parity bit: even = XOR of the dlen data bits; odd = its inverse; mark = 1.
    - Bits above dlen are ignored.
  - STOP: line high for 1 or 2 bit periods. On the final tick tx_done pulses.
    - Goes directly to START (same IDLE conditions, pop on that edge) with no gap.
    - Otherwise goes to IDLE; tx_busy=0 in the following cycle.
- cfg_en deasserted in any non-IDLE state: abort to IDLE next edge, uart_tx=1, no tx_done, frame data lost, FIFO retained.
- Frame length in cycles = (div+1) × (1 + dlen + (par!=0) + 1 + stop2).

Decomposition:
- Package uart_pkg: FSM state enum, parity codes (PAR_NONE/EVEN/ODD/MARK), DLEN_MIN=5, DLEN_DEF=8, a function returning the effective dlen.
- Sub-module uart_sync_fifo (params DEPTH, WIDTH): provides level/empty/full/flush. It is reusable by the future RX engine.
- The top level holds the CTS synchroniser, baud counter and FSM.

Test Plan:
- 8N1, div=3, write 0x55: uart_tx low 4 cycles starting 1 cycle after pop, then 1,0,1,0,1,0,1,0 at 4 cycles each, high 4 cycles; tx_done at cycle 40 of the frame.
- 7E2, div=0, write 0x7F (seven ones): parity bit 1, two stop bits, frame 11 cycles. 9O1, div=1, data 0x1FF: parity 0, frame 24 cycles.
- Write 17 words with DEPTH=16 and the FSM blocked by CTS high: wr_ready drops after 16 words, fifo_full=1, fifo_level=16. Drop CTS: back-to-back frames with no idle cycle between stop and start.
- Change cfg_div from 3 to 7 mid-frame: current frame keeps 4-cycle bits; the next frame uses 8-cycle bits.
- Deassert cfg_en mid-DATA: uart_tx=1 next edge, no tx_done, fifo_level unchanged. cfg_flush asserted together with wr_valid: level 0.
- Assert prst_n=0 mid-frame for 1 cycle: all outputs at reset values on the next edge, FIFO empty.
